id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 168 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode and EX-stage operand forwarding.
// Forwarding and decode are combinational on the registered state so they track bypass inputs during a stall.
module id_ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        ALUSrc_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] imm_i,
  input  logic [6:0]  funct7_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        EXMEM_RegWrite_i,
  input  logic [4:0]  EXMEM_rd_i,
  input  logic [31:0] EXMEM_data_i,
  input  logic        MEMWB_RegWrite_i,
  input  logic [4:0]  MEMWB_rd_i,
  input  logic [31:0] MEMWB_data_i,
  output logic [31:0] data1_o,
  output logic [31:0] data2_o,
  output logic [2:0]  ALUCtrl_o,
  output logic [31:0] store_data_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        valid_o,
  output logic [4:0]  rd_addr_o,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_XOR  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_MUL  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_SRAI = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef struct packed {
    logic            reg_write;
    logic            mem_to_reg;
    logic            mem_read;
    logic            mem_write;
    logic            alu_src;
    logic [1:0]      alu_op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [AW-1:0]   rd_addr;
    logic            valid;
  } id_ex_t;

  id_ex_t d, q;
  logic [2:0]      alu_ctrl;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  assign d = '{
    reg_write:  RegWrite_i,
    mem_to_reg: MemtoReg_i,
    mem_read:   MemRead_i,
    mem_write:  MemWrite_i,
    alu_src:    ALUSrc_i,
    alu_op:     ALUOp_i,
    rs1_data:   rs1_data_i,
    rs2_data:   rs2_data_i,
    imm:        imm_i,
    funct7:     funct7_i,
    funct3:     funct3_i,
    rs1_addr:   rs1_addr_i,
    rs2_addr:   rs2_addr_i,
    rd_addr:    rd_addr_i,
    valid:      1'b1
  };

  // Flush beats stall; an all-zero register is the bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)        q <= '0;
    else if (flush_i)  q <= '0;
    else if (!stall_i) q <= d;
  end

  // ALU control decode; any undefined combination falls back to ADD.
  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (q.alu_op)
      2'b00: alu_ctrl = ALU_ADD;
      2'b01: alu_ctrl = ALU_SUB;
      2'b10: begin
        case ({q.funct7, q.funct3})
          {F7_BASE, 3'b111}: alu_ctrl = ALU_AND;
          {F7_BASE, 3'b100}: alu_ctrl = ALU_XOR;
          {F7_BASE, 3'b001}: alu_ctrl = ALU_SLL;
          {F7_BASE, 3'b000}: alu_ctrl = ALU_ADD;
          {F7_ALT,  3'b000}: alu_ctrl = ALU_SUB;
          {F7_MUL,  3'b000}: alu_ctrl = ALU_MUL;
          {F7_BASE, 3'b010}: alu_ctrl = ALU_SLT;
          default:           alu_ctrl = ALU_ADD;
        endcase
      end
      2'b11: begin
        case (q.funct3)
          3'b000:  alu_ctrl = ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b101:  alu_ctrl = (q.funct7 == F7_ALT) ? ALU_SRAI : ALU_ADD;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  // Bypass: EX/MEM result is younger than MEM/WB, so it wins; x0 never forwards.
  always_comb begin
    fwd_a = q.rs1_data;
    if (EXMEM_RegWrite_i && (EXMEM_rd_i != '0) && (EXMEM_rd_i == q.rs1_addr))
      fwd_a = EXMEM_data_i;
    else if (MEMWB_RegWrite_i && (MEMWB_rd_i != '0) && (MEMWB_rd_i == q.rs1_addr))
      fwd_a = MEMWB_data_i;
  end

  always_comb begin
    fwd_b = q.rs2_data;
    if (EXMEM_RegWrite_i && (EXMEM_rd_i != '0) && (EXMEM_rd_i == q.rs2_addr))
      fwd_b = EXMEM_data_i;
    else if (MEMWB_RegWrite_i && (MEMWB_rd_i != '0) && (MEMWB_rd_i == q.rs2_addr))
      fwd_b = MEMWB_data_i;
  end

  assign ALUCtrl_o    = alu_ctrl;
  assign data1_o      = fwd_a;
  assign data2_o      = q.alu_src ? q.imm : fwd_b;
  assign store_data_o = fwd_b;

  assign RegWrite_o = q.reg_write;
  assign MemtoReg_o = q.mem_to_reg;
  assign MemRead_o  = q.mem_read;
  assign MemWrite_o = q.mem_write;
  assign valid_o    = q.valid;
  assign rd_addr_o  = q.rd_addr;
  assign rs1_addr_o = q.rs1_addr;
  assign rs2_addr_o = q.rs2_addr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected output snapshots are queued with stimulus and popped on observation.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall_i = 1'b0, flush_i = 1'b0;
  logic        RegWrite_i = 1'b0, MemtoReg_i = 1'b0, MemRead_i = 1'b0, MemWrite_i = 1'b0, ALUSrc_i = 1'b0;
  logic [1:0]  ALUOp_i = '0;
  logic [31:0] rs1_data_i = '0, rs2_data_i = '0, imm_i = '0;
  logic [6:0]  funct7_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [4:0]  rs1_addr_i = '0, rs2_addr_i = '0, rd_addr_i = '0;
  logic        EXMEM_RegWrite_i = 1'b0, MEMWB_RegWrite_i = 1'b0;
  logic [4:0]  EXMEM_rd_i = '0, MEMWB_rd_i = '0;
  logic [31:0] EXMEM_data_i = '0, MEMWB_data_i = '0;
  logic [31:0] data1_o, data2_o, store_data_o;
  logic [2:0]  ALUCtrl_o;
  logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, valid_o;
  logic [4:0]  rd_addr_o, rs1_addr_o, rs2_addr_o;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] sd;
    logic        rw, m2r, mr, mw, v;
    logic [4:0]  rd, rs1, rs2;
  } obs_t;

  obs_t sb[$];
  int total = 0;
  int bad = 0;

  id_ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .funct7_i(funct7_i), .funct3_i(funct3_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .EXMEM_RegWrite_i(EXMEM_RegWrite_i), .EXMEM_rd_i(EXMEM_rd_i), .EXMEM_data_i(EXMEM_data_i),
    .MEMWB_RegWrite_i(MEMWB_RegWrite_i), .MEMWB_rd_i(MEMWB_rd_i), .MEMWB_data_i(MEMWB_data_i),
    .data1_o(data1_o), .data2_o(data2_o), .ALUCtrl_o(ALUCtrl_o), .store_data_o(store_data_o),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .valid_o(valid_o),
    .rd_addr_o(rd_addr_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic obs_t snap();
    return '{ctrl: ALUCtrl_o, d1: data1_o, d2: data2_o, sd: store_data_o,
             rw: RegWrite_o, m2r: MemtoReg_o, mr: MemRead_o, mw: MemWrite_o, v: valid_o,
             rd: rd_addr_o, rs1: rs1_addr_o, rs2: rs2_addr_o};
  endfunction

  function automatic obs_t mk(logic [2:0] ctrl, logic [31:0] d1, logic [31:0] d2, logic [31:0] sd,
                              logic [3:0] ctl, logic v, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return '{ctrl: ctrl, d1: d1, d2: d2, sd: sd, rw: ctl[3], m2r: ctl[2], mr: ctl[1], mw: ctl[0],
             v: v, rd: rd, rs1: rs1, rs2: rs2};
  endfunction

  // ctl = {RegWrite, MemtoReg, MemRead, MemWrite}
  task automatic drive_id(input logic [3:0] ctl, input logic alusrc, input logic [1:0] aluop,
                          input logic [31:0] r1d, input logic [31:0] r2d, input logic [31:0] imm,
                          input logic [6:0] f7, input logic [2:0] f3,
                          input logic [4:0] r1a, input logic [4:0] r2a, input logic [4:0] rda);
    {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i} = ctl;
    ALUSrc_i = alusrc; ALUOp_i = aluop;
    rs1_data_i = r1d; rs2_data_i = r2d; imm_i = imm;
    funct7_i = f7; funct3_i = f3;
    rs1_addr_i = r1a; rs2_addr_i = r2a; rd_addr_i = rda;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_fwd();
    EXMEM_RegWrite_i = 1'b0; EXMEM_rd_i = '0; EXMEM_data_i = '0;
    MEMWB_RegWrite_i = 1'b0; MEMWB_rd_i = '0; MEMWB_data_i = '0;
  endtask

  task automatic test_reset();
    obs_t e, o;
    drive_id(4'b1111, 1'b1, 2'b10, 32'h1234, 32'h5678, 32'h9, 7'h01, 3'h0, 5'd3, 5'd4, 5'd5);
    #2;
    sb.push_back(mk(3'b011, '0, '0, '0, 4'b0000, 1'b0, '0, '0, '0));
    e = sb.pop_front(); o = snap(); total++;
    if (o !== e) begin bad++; $display("FAIL reset_initial got=%h exp=%h", o, e); end
    sb.push_back(mk(3'b011, '0, '0, '0, 4'b0000, 1'b0, '0, '0, '0));
    step();
    e = sb.pop_front(); o = snap(); total++;
    if (o !== e) begin bad++; $display("FAIL reset_edge_ignored got=%h exp=%h", o, e); end
    #2 rst_i = 1'b1;
    #2;
  endtask

  task automatic test_rtype_add();
    obs_t e, o;
    drive_id(4'b1000, 1'b0, 2'b10, 32'd5, 32'd7, 32'd0, 7'h00, 3'h0, 5'd1, 5'd2, 5'd3);
    sb.push_back(mk(3'b011, 32'd5, 32'd7, 32'd7, 4'b1000, 1'b1, 5'd3, 5'd1, 5'd2));
    step();
    e = sb.pop_front(); o = snap(); total++;
    if (o !== e) begin bad++; $display("FAIL rtype_add got=%h exp=%h", o, e); end
  endtask

  // Back-to-back decode sweep, one instruction per cycle.
  task automatic test_decode();
    logic [1:0] op [17] = '{2'b10,2'b10,2'b10,2'b10,2'b10,2'b10,2'b10,2'b10,2'b10,
                            2'b00,2'b01,2'b11,2'b11,2'b11,2'b11,2'b11,2'b11};
    logic [6:0] f7 [17] = '{7'h00,7'h00,7'h00,7'h00,7'h20,7'h01,7'h00,7'h00,7'h20,
                            7'h20,7'h00,7'h00,7'h00,7'h00,7'h20,7'h00,7'h00};
    logic [2:0] f3 [17] = '{3'd7,3'd4,3'd1,3'd0,3'd0,3'd0,3'd2,3'd3,3'd7,
                            3'd0,3'd7,3'd0,3'd2,3'd1,3'd5,3'd5,3'd7};
    logic [2:0] ex [17] = '{3'b000,3'b001,3'b010,3'b011,3'b100,3'b101,3'b110,3'b011,3'b011,
                            3'b011,3'b100,3'b011,3'b110,3'b010,3'b111,3'b011,3'b011};
    obs_t e, o;
    logic [31:0] r1d, r2d;
    logic [3:0] ctl;
    for (int i = 0; i < 17; i++) begin
      r1d = 32'(100 + i);
      r2d = 32'(7 * i + 1);
      ctl = {1'b1, i[0], i[0], i[1]};
      drive_id(ctl, 1'b0, op[i], r1d, r2d, 32'(i), f7[i], f3[i], 5'(i + 1), 5'(i + 2), 5'(i + 3));
      sb.push_back(mk(ex[i], r1d, r2d, r2d, ctl, 1'b1, 5'(i + 3), 5'(i + 1), 5'(i + 2)));
      step();
      e = sb.pop_front(); o = snap(); total++;
      if (o !== e) begin bad++; $display("FAIL decode_%0d got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_srai_mul();
    obs_t e, o;
    drive_id(4'b1000, 1'b1, 2'b11, 32'hF0, 32'h44, 32'd3, 7'b0100000, 3'b101, 5'd6, 5'd7, 5'd8);
    sb.push_back(mk(3'b111, 32'hF0, 32'd3, 32'h44, 4'b1000, 1'b1, 5'd8, 5'd6, 5'd7));
    step();
    e = sb.pop_front(); o = snap(); total++;
    if (o !== e) begin bad++; $display("FAIL srai got=%h exp=%h", o, e); end
    drive_id(4'b1000, 1'b0, 2'b10, 32'd6, 32'd9, 32'd0, 7'b0000001, 3'b000, 5'd9, 5'd10, 5'd11);
    sb.push_back(mk(3'b101, 32'd6, 32'd9, 32'd9, 4'b1000, 1'b1, 5'd11, 5'd9, 5'd10));
    step();
    e = sb.pop_front(); o = snap(); total++;
    if (o !== e) begin bad++; $display("FAIL mul got=%h exp=%h", o, e); end
  endtask

  task automatic test_forward();
    obs_t e, o;
    drive_id(4'b1000, 1'b0, 2'b10, 32'h11, 32'h22, 32'h0, 7'h00, 3'h0, 5'd4, 5'd4, 5'd12);
    step();
    EXMEM_RegWrite_i = 1'b1; EXMEM_rd_i = 5'd4; EXMEM_data_i = 32'hAA;
    MEMWB_RegWrite_i = 1'b1; MEMWB_rd_i = 5'd4; MEMWB_data_i = 32'hBB;
    sb.push_back(mk(3'b011, 32'hAA, 32'hAA, 32'hAA, 4'b1000, 1'b1, 5'd12, 5'd4, 5'd4));
    #1;
    e = sb.pop_front(); o = snap(); total++;
    if (o !== e) begin bad++; $display("FAIL fwd_exmem_priority got=%h exp=%h", o, e); end
    EXMEM_RegWrite_i = 1'b0;
    sb.push_back(mk(3'b011, 32'hBB, 32'hBB, 32'hBB, 4'b1000, 1'b1, 5'd12, 5'd4, 5'd4));
    #1;
    e = sb.pop_front(); o = snap(); total++;
    if (o !== e) begin bad++; $display("FAIL fwd_memwb got=%h exp=%h", o, e); end
    EXMEM_RegWrite_i = 1'b1; EXMEM_rd_i = 5'd0; MEMWB_rd_i = 5'd0;
    sb.push_back(mk(3'b011, 32'h11, 32'h22, 32'h22, 4'b1000, 1'b1, 5'd12, 5'd4, 5'd4));
    #1;
    e = sb.pop_front(); o = snap(); total++;
    if (o !== e) begin bad++; $display("FAIL fwd_rd0_none got=%h exp=%h", o, e); end
    // Source x0 must not pick up a bypass even if a writer claims x0.
    drive_id(4'b1000, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0, 7'h00, 3'h0, 5'd0, 5'd0, 5'd13);
    sb.push_back(mk(3'b011, 32'h0, 32'h0, 32'h0, 4'b1000, 1'b1, 5'd13, 5'd0, 5'd0));
    step();
    e = sb.pop_front(); o = snap(); total++;
    if (o !== e) begin bad++; $display("FAIL fwd_x0_source got=%h exp=%h", o, e); end
    clear_fwd();
  endtask

  task automatic test_store();
    obs_t e, o;
    drive_id(4'b0001, 1'b1, 2'b00, 32'h100, 32'h99, 32'd8, 7'h00, 3'b010, 5'd2, 5'd6, 5'd0);
    MEMWB_RegWrite_i = 1'b1; MEMWB_rd_i = 5'd6; MEMWB_data_i = 32'h55;
    sb.push_back(mk(3'b011, 32'h100, 32'd8, 32'h55, 4'b0001, 1'b1, 5'd0, 5'd2, 5'd6));
    step();
    e = sb.pop_front(); o = snap(); total++;
    if (o !== e) begin bad++; $display("FAIL store_fwd got=%h exp=%h", o, e); end
    clear_fwd();
  endtask

  task automatic test_stall_flush();
    obs_t e, o, held;
    drive_id(4'b1010, 1'b0, 2'b10, 32'h31, 32'h32, 32'h0, 7'h20, 3'h0, 5'd14, 5'd15, 5'd16);
    held = mk(3'b100, 32'h31, 32'h32, 32'h32, 4'b1010, 1'b1, 5'd16, 5'd14, 5'd15);
    sb.push_back(held);
    step();
    e = sb.pop_front(); o = snap(); total++;
    if (o !== e) begin bad++; $display("FAIL stall_setup got=%h exp=%h", o, e); end
    stall_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive_id(4'b0101, 1'b1, 2'b11, 32'(c + 200), 32'(c + 300), 32'hFF, 7'h00, 3'h2, 5'd20, 5'd21, 5'd22);
      sb.push_back(held);
      step();
      e = sb.pop_front(); o = snap(); total++;
      if (o !== e) begin bad++; $display("FAIL stall_hold_%0d got=%h exp=%h", c, o, e); end
    end
    EXMEM_RegWrite_i = 1'b1; EXMEM_rd_i = 5'd14; EXMEM_data_i = 32'hC0DE;
    sb.push_back(mk(3'b100, 32'hC0DE, 32'h32, 32'h32, 4'b1010, 1'b1, 5'd16, 5'd14, 5'd15));
    #1;
    e = sb.pop_front(); o = snap(); total++;
    if (o !== e) begin bad++; $display("FAIL stall_fwd_tracks got=%h exp=%h", o, e); end
    clear_fwd();
    flush_i = 1'b1;
    sb.push_back(mk(3'b011, '0, '0, '0, 4'b0000, 1'b0, '0, '0, '0));
    step();
    e = sb.pop_front(); o = snap(); total++;
    if (o !== e) begin bad++; $display("FAIL flush_over_stall got=%h exp=%h", o, e); end
    flush_i = 1'b0; stall_i = 1'b0;
    drive_id(4'b1000, 1'b0, 2'b01, 32'd50, 32'd20, 32'd0, 7'h00, 3'h0, 5'd17, 5'd18, 5'd19);
    sb.push_back(mk(3'b100, 32'd50, 32'd20, 32'd20, 4'b1000, 1'b1, 5'd19, 5'd17, 5'd18));
    step();
    e = sb.pop_front(); o = snap(); total++;
    if (o !== e) begin bad++; $display("FAIL resume_after_flush got=%h exp=%h", o, e); end
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    drive_id(4'b1100, 1'b0, 2'b10, 32'h77, 32'h88, 32'h0, 7'h00, 3'h4, 5'd23, 5'd24, 5'd25);
    step();
    stall_i = 1'b1;
    #2 rst_i = 1'b0;
    sb.push_back(mk(3'b011, '0, '0, '0, 4'b0000, 1'b0, '0, '0, '0));
    #1;
    e = sb.pop_front(); o = snap(); total++;
    if (o !== e) begin bad++; $display("FAIL async_reset_clear got=%h exp=%h", o, e); end
    #1 rst_i = 1'b1;
    stall_i = 1'b0;
    drive_id(4'b1000, 1'b0, 2'b10, 32'h3, 32'h4, 32'h0, 7'h00, 3'h1, 5'd26, 5'd27, 5'd28);
    sb.push_back(mk(3'b010, 32'h3, 32'h4, 32'h4, 4'b1000, 1'b1, 5'd28, 5'd26, 5'd27));
    step();
    e = sb.pop_front(); o = snap(); total++;
    if (o !== e) begin bad++; $display("FAIL post_reset_capture got=%h exp=%h", o, e); end
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_decode();
    test_srai_mul();
    test_forward();
    test_store();
    test_stall_flush();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
